ddiff_chain: RTL and testbench

- Parametrised chain of delayed differences on a sign-magnitude sample stream.
- Produces difference orders 1..ORDER for every accepted sample: dd1 = x[n]-x[n-1], ddk = dd(k-1)[n]-dd(k-1)[n-1].
- Adds a sample-valid handshake, per-order warm-up status, saturate/wrap mode, sticky overflow flags and a synchronous flush.
- Sits between the sample source and the ANS/PWM predictor logic.

---
 rtl/ddiff_chain.sv | 171 +++++++++++++++++
 tb/tb_ddiff_chain.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ddiff_chain.sv
// ddiff_chain
// ------------------------------------------------------------------------
// Chain of delayed differences on a sign-magnitude sample stream. Every
// accepted sample produces difference orders 1..ORDER in the same clock:
//   dd1 = x[n] - x[n-1]
//   ddk = dd(k-1)[n] - dd(k-1)[n-1]
// Each order's registered output is the history operand of the next order.
// Results are returned in sign-magnitude form and are either saturated or
// wrapped to WIDTH bits. Each order has a sticky overflow flag and a warm-up
// ("primed") status bit.
//
// Parameters
//   WIDTH    magnitude width of the input and of every difference output
//   ORDER    number of difference stages (1..8)
//   SATURATE 1 = clamp overflowed magnitudes to all ones, 0 = keep low bits
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   clear     synchronous flush of history, outputs, warm-up and flags
//   in_valid  A / A_sign carry a new sample this cycle
//   A         input magnitude
//   A_sign    input sign, 1 = non-negative
//   out_valid one-cycle pulse after every accepted sample
//   dd_mag    order k magnitude at [k*WIDTH-1 : (k-1)*WIDTH]
//   dd_sign   order k sign at bit k-1, 1 = non-negative
//   primed    bit k-1 high once order k has a full history
//   ovf       sticky overflow flag per order
// ------------------------------------------------------------------------
module ddiff_chain #(
  parameter int WIDTH    = 16,
  parameter int ORDER    = 3,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         A,
  input  logic                     A_sign,
  output logic                     out_valid,
  output logic [ORDER*WIDTH-1:0]   dd_mag,
  output logic [ORDER-1:0]         dd_sign,
  output logic [ORDER-1:0]         primed,
  output logic [ORDER-1:0]         ovf
);

  // Two extra bits hold the exact difference of two WIDTH-bit magnitudes:
  // the range is +/-(2^(WIDTH+1)-2), which needs WIDTH+1 magnitude bits and
  // a sign bit.
  localparam int XW = WIDTH + 2;

  // The accept counter only needs to reach ORDER+1, at which point every
  // order is primed; it then saturates.
  localparam int CW = $clog2(ORDER + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(ORDER + 1);

  logic [WIDTH-1:0] hist_mag;
  logic             hist_sign;
  logic [CW-1:0]    acc_cnt;

  logic [WIDTH-1:0] new_mag [ORDER];
  logic [ORDER-1:0] new_sign;
  logic [ORDER-1:0] new_ovf;

  // Sign-magnitude to two's complement. A negative zero maps to zero, so
  // -0 and +0 are the same operand everywhere in the chain.
  function automatic logic signed [XW-1:0] to_tc(input logic [WIDTH-1:0] mag,
                                                 input logic sgn);
    logic signed [XW-1:0] ext;
    ext = $signed({2'b00, mag});
    return sgn ? ext : -ext;
  endfunction

  // Combinational difference chain. Stage 0 subtracts the stored previous
  // input; stage k subtracts the registered output of stage k-1 from the
  // freshly computed (already saturated/wrapped) result of stage k-1, so all
  // orders are ready for the same clock edge.
  always_comb begin
    logic signed [XW-1:0] a_tc;
    logic signed [XW-1:0] b_tc;
    logic signed [XW-1:0] diff;
    logic [XW-1:0]        absval;
    logic [WIDTH-1:0]     mag;
    logic                 sgn;
    logic                 of;
    a_tc     = '0;
    b_tc     = '0;
    diff     = '0;
    absval   = '0;
    mag      = '0;
    sgn      = 1'b1;
    of       = 1'b0;
    new_sign = '1;
    new_ovf  = '0;
    for (int k = 0; k < ORDER; k++) begin
      new_mag[k] = '0;
    end
    for (int k = 0; k < ORDER; k++) begin
      if (k == 0) begin
        a_tc = to_tc(A, A_sign);
        b_tc = to_tc(hist_mag, hist_sign);
      end else begin
        a_tc = to_tc(new_mag[k-1], new_sign[k-1]);
        b_tc = to_tc(dd_mag[(k-1)*WIDTH +: WIDTH], dd_sign[k-1]);
      end
      diff   = a_tc - b_tc;
      absval = diff[XW-1] ? $unsigned(-diff) : $unsigned(diff);
      // Anything in the top two bits of the magnitude exceeds 2^WIDTH-1.
      of     = |absval[XW-1:WIDTH];
      if (of && (SATURATE != 0)) begin
        mag = '1;
      end else begin
        mag = absval[WIDTH-1:0];
      end
      // Zero, including a wrapped-to-zero overflow, is always reported +0.
      sgn = ~diff[XW-1] | (mag == '0);
      new_mag[k]  = mag;
      new_sign[k] = sgn;
      new_ovf[k]  = of;
    end
  end

  // State register. Reset and clear return everything to +0 history, zero
  // outputs with positive sign, no warm-up and no overflow. A clear in the
  // same cycle as in_valid drops the sample. An idle cycle holds everything
  // and only drops out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_mag  <= '0;
      hist_sign <= 1'b1;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      dd_mag    <= '0;
      dd_sign   <= '1;
      ovf       <= '0;
    end else if (clear) begin
      hist_mag  <= '0;
      hist_sign <= 1'b1;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      dd_mag    <= '0;
      dd_sign   <= '1;
      ovf       <= '0;
    end else if (in_valid) begin
      hist_mag  <= A;
      hist_sign <= A_sign | (A == '0);
      if (acc_cnt != CNT_MAX) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      out_valid <= 1'b1;
      for (int k = 0; k < ORDER; k++) begin
        dd_mag[k*WIDTH +: WIDTH] <= new_mag[k];
      end
      dd_sign <= new_sign;
      ovf     <= ovf | new_ovf;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Order k has a true difference once k+1 samples have been accepted, i.e.
  // the counter (samples accepted so far) has reached k+1.
  always_comb begin
    primed = '0;
    for (int k = 0; k < ORDER; k++) begin
      primed[k] = (acc_cnt >= CW'(k + 2));
    end
  end

endmodule

// File: tb/tb_ddiff_chain.sv
// tb_ddiff_chain
// Directed bench for ddiff_chain. Four instances share one input stream:
// the default build (WIDTH=16, ORDER=3, SATURATE=1), a wrapping build, and
// ORDER=1 / ORDER=8 builds for checking the output packing.
module tb_ddiff_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic        A_sign = 1'b1;

  logic         m_ov, w_ov, o1_ov, o8_ov;
  logic [47:0]  m_mag, w_mag;
  logic [2:0]   m_sign, m_primed, m_ovf, w_sign, w_primed, w_ovf;
  logic [15:0]  o1_mag;
  logic [0:0]   o1_sign, o1_primed, o1_ovf;
  logic [127:0] o8_mag;
  logic [7:0]   o8_sign, o8_primed, o8_ovf;

  int errors = 0;
  int checks = 0;

  ddiff_chain #(.WIDTH(16), .ORDER(3), .SATURATE(1)) u_main (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .A(A), .A_sign(A_sign),
    .out_valid(m_ov), .dd_mag(m_mag), .dd_sign(m_sign), .primed(m_primed), .ovf(m_ovf));

  ddiff_chain #(.WIDTH(16), .ORDER(3), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .A(A), .A_sign(A_sign),
    .out_valid(w_ov), .dd_mag(w_mag), .dd_sign(w_sign), .primed(w_primed), .ovf(w_ovf));

  ddiff_chain #(.WIDTH(16), .ORDER(1), .SATURATE(1)) u_o1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .A(A), .A_sign(A_sign),
    .out_valid(o1_ov), .dd_mag(o1_mag), .dd_sign(o1_sign), .primed(o1_primed), .ovf(o1_ovf));

  ddiff_chain #(.WIDTH(16), .ORDER(8), .SATURATE(1)) u_o8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .A(A), .A_sign(A_sign),
    .out_valid(o8_ov), .dd_mag(o8_mag), .dd_sign(o8_sign), .primed(o8_primed), .ovf(o8_ovf));

  always #5 clk = ~clk;

  // Presents one sample starting at a falling edge; returns on the next
  // falling edge, half a cycle after the accepting rising edge.
  task automatic send(input logic [15:0] mag, input logic sgn);
    A        = mag;
    A_sign   = sgn;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (m_mag !== 48'd0) begin errors++; $display("[TB] FAIL reset dd_mag: got %h expected 0", m_mag); end
    checks++; if (m_sign !== 3'b111) begin errors++; $display("[TB] FAIL reset dd_sign: got %b expected 111", m_sign); end
    checks++; if (m_primed !== 3'b000) begin errors++; $display("[TB] FAIL reset primed: got %b expected 000", m_primed); end
    checks++; if (m_ovf !== 3'b000) begin errors++; $display("[TB] FAIL reset ovf: got %b expected 000", m_ovf); end
    checks++; if (m_ov !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b expected 0", m_ov); end
    checks++; if (o8_sign !== 8'hFF) begin errors++; $display("[TB] FAIL reset o8 dd_sign: got %h expected ff", o8_sign); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Ramp +10,+20,+30,+40 back to back from a fresh state.
  task automatic test_ramp(input string tag);
    logic [15:0] em [4][3] = '{'{16'd10, 16'd10, 16'd10}, '{16'd10, 16'd0, 16'd10},
                               '{16'd10, 16'd0, 16'd0},   '{16'd10, 16'd0, 16'd0}};
    logic [2:0]  es [4] = '{3'b111, 3'b011, 3'b111, 3'b111};
    logic [2:0]  ep [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    for (int i = 0; i < 4; i++) begin
      send(16'(10 * (i + 1)), 1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (m_mag[k*16 +: 16] !== em[i][k]) begin
          errors++; $display("[TB] FAIL %s[%0d] dd%0d mag: got %0d expected %0d", tag, i, k + 1, m_mag[k*16 +: 16], em[i][k]);
        end
      end
      checks++; if (m_sign !== es[i]) begin errors++; $display("[TB] FAIL %s[%0d] dd_sign: got %b expected %b", tag, i, m_sign, es[i]); end
      checks++; if (m_primed !== ep[i]) begin errors++; $display("[TB] FAIL %s[%0d] primed: got %b expected %b", tag, i, m_primed, ep[i]); end
      checks++; if (m_ov !== 1'b1) begin errors++; $display("[TB] FAIL %s[%0d] out_valid: got %b expected 1", tag, i, m_ov); end
      checks++; if (o1_mag !== 16'd10 || o1_sign !== 1'b1) begin errors++; $display("[TB] FAIL %s[%0d] o1 dd1: got %0d/%b expected 10/1", tag, i, o1_mag, o1_sign); end
      checks++; if (o1_primed !== ((i >= 1) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL %s[%0d] o1 primed: got %b", tag, i, o1_primed); end
      if (i == 1) begin
        checks++;
        if (o8_mag !== {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd0, 16'd10}) begin
          errors++; $display("[TB] FAIL %s[1] o8 dd_mag: got %h", tag, o8_mag);
        end
        checks++; if (o8_sign !== 8'h03) begin errors++; $display("[TB] FAIL %s[1] o8 dd_sign: got %h expected 03", tag, o8_sign); end
        checks++; if (o8_primed !== 8'h01) begin errors++; $display("[TB] FAIL %s[1] o8 primed: got %h expected 01", tag, o8_primed); end
      end
      if (i == 3) begin
        checks++;
        if (o8_mag !== {16'd200, 16'd100, 16'd40, 16'd10, 16'd0, 16'd0, 16'd0, 16'd10}) begin
          errors++; $display("[TB] FAIL %s[3] o8 dd_mag: got %h", tag, o8_mag);
        end
        checks++; if (o8_sign !== 8'h0F) begin errors++; $display("[TB] FAIL %s[3] o8 dd_sign: got %h expected 0f", tag, o8_sign); end
        checks++; if (o8_primed !== 8'h07) begin errors++; $display("[TB] FAIL %s[3] o8 primed: got %h expected 07", tag, o8_primed); end
        checks++; if (o8_ovf !== 8'h00) begin errors++; $display("[TB] FAIL %s[3] o8 ovf: got %h expected 00", tag, o8_ovf); end
      end
    end
    @(negedge clk);
    checks++; if (m_ov !== 1'b0) begin errors++; $display("[TB] FAIL %s idle out_valid: got %b expected 0", tag, m_ov); end
    checks++; if (m_mag !== {16'd0, 16'd0, 16'd10}) begin errors++; $display("[TB] FAIL %s idle hold: got %h", tag, m_mag); end
  endtask

  // Squares with idle gaps; outputs must hold across the gaps.
  task automatic test_quadratic();
    logic [15:0] xin [5] = '{16'd1, 16'd4, 16'd9, 16'd16, 16'd25};
    logic [15:0] e1 [5]  = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};
    logic [15:0] e2 [5]  = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
    logic [15:0] e3 [5]  = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0};
    logic [2:0]  ep [5]  = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111};
    int          gap [5] = '{2, 0, 3, 1, 0};
    logic [47:0] expv;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      send(xin[i], 1'b1);
      expv = {e3[i], e2[i], e1[i]};
      checks++; if (m_mag !== expv) begin errors++; $display("[TB] FAIL quad[%0d] dd_mag: got %h expected %h", i, m_mag, expv); end
      checks++; if (m_sign !== 3'b111 || m_ov !== 1'b1) begin errors++; $display("[TB] FAIL quad[%0d] sign/valid: got %b/%b expected 111/1", i, m_sign, m_ov); end
      checks++; if (m_primed !== ep[i]) begin errors++; $display("[TB] FAIL quad[%0d] primed: got %b expected %b", i, m_primed, ep[i]); end
      for (int g = 0; g < gap[i]; g++) begin
        @(negedge clk);
        checks++;
        if (m_ov !== 1'b0 || m_mag !== expv) begin
          errors++; $display("[TB] FAIL quad[%0d] gap hold: got %b/%h expected 0/%h", i, m_ov, m_mag, expv);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_clear();
    send(16'd65535, 1'b1);
    send(16'd65535, 1'b0);
    checks++; if (m_mag[15:0] !== 16'd65535 || m_sign[0] !== 1'b0) begin errors++; $display("[TB] FAIL ovf sat dd1: got %0d/%b expected 65535/0", m_mag[15:0], m_sign[0]); end
    checks++; if (m_ovf[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf sat flag: got %b expected 1", m_ovf[0]); end
    checks++; if (w_mag[15:0] !== 16'd65534 || w_sign[0] !== 1'b0) begin errors++; $display("[TB] FAIL ovf wrap dd1: got %0d/%b expected 65534/0", w_mag[15:0], w_sign[0]); end
    checks++; if (w_ovf[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf wrap flag: got %b expected 1", w_ovf[0]); end
    // 0 - (-65535) = 65535 fits, then +5 - 0 = 5; neither overflows order 1.
    send(16'd0, 1'b1);
    send(16'd5, 1'b1);
    checks++; if (m_mag[15:0] !== 16'd5 || m_sign[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf later dd1: got %0d/%b expected 5/1", m_mag[15:0], m_sign[0]); end
    checks++; if (m_ovf[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf sticky sat: got %b expected 1", m_ovf[0]); end
    checks++; if (w_ovf[0] !== 1'b1) begin errors++; $display("[TB] FAIL ovf sticky wrap: got %b expected 1", w_ovf[0]); end
  endtask

  task automatic test_signed_zero();
    do_clear();
    send(16'd5, 1'b0);
    checks++; if (m_mag[15:0] !== 16'd5 || m_sign[0] !== 1'b0) begin errors++; $display("[TB] FAIL zero first dd1: got %0d/%b expected 5/0", m_mag[15:0], m_sign[0]); end
    send(16'd5, 1'b0);
    checks++; if (m_mag[15:0] !== 16'd0 || m_sign[0] !== 1'b1) begin errors++; $display("[TB] FAIL zero -5-(-5): got %0d/%b expected 0/1", m_mag[15:0], m_sign[0]); end
    checks++; if (m_mag[31:16] !== 16'd5 || m_sign[1] !== 1'b1) begin errors++; $display("[TB] FAIL zero dd2: got %0d/%b expected 5/1", m_mag[31:16], m_sign[1]); end
    send(16'd0, 1'b1);
    checks++; if (m_mag[15:0] !== 16'd5 || m_sign[0] !== 1'b1) begin errors++; $display("[TB] FAIL zero +0 dd1: got %0d/%b expected 5/1", m_mag[15:0], m_sign[0]); end
    send(16'd0, 1'b0);
    checks++; if (m_mag[15:0] !== 16'd0 || m_sign[0] !== 1'b1) begin errors++; $display("[TB] FAIL zero -0 dd1: got %0d/%b expected 0/1", m_mag[15:0], m_sign[0]); end
    // dd1 seq -5,0,5,0 -> dd2 -5,5,5,-5 -> dd3 -5,10,0,-10
    checks++; if (m_mag !== {16'd10, 16'd5, 16'd0} || m_sign !== 3'b001) begin errors++; $display("[TB] FAIL zero chain: got %h/%b expected 000a00050000/001", m_mag, m_sign); end
    send(16'd3, 1'b1);
    checks++; if (m_mag[15:0] !== 16'd3 || m_sign[0] !== 1'b1) begin errors++; $display("[TB] FAIL zero after -0 dd1: got %0d/%b expected 3/1", m_mag[15:0], m_sign[0]); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 1; i <= 4; i++) send(16'(10 * i), 1'b1);
    A = 16'd100; A_sign = 1'b1; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    checks++; if (m_mag !== 48'd0 || m_sign !== 3'b111) begin errors++; $display("[TB] FAIL clear dd: got %h/%b expected 0/111", m_mag, m_sign); end
    checks++; if (m_primed !== 3'b000 || m_ovf !== 3'b000) begin errors++; $display("[TB] FAIL clear flags: got %b/%b expected 000/000", m_primed, m_ovf); end
    checks++; if (m_ov !== 1'b0) begin errors++; $display("[TB] FAIL clear out_valid: got %b expected 0", m_ov); end
    send(16'd7, 1'b1);
    checks++; if (m_mag !== {16'd7, 16'd7, 16'd7} || m_sign !== 3'b111) begin errors++; $display("[TB] FAIL clear next dd: got %h/%b expected 000700070007/111", m_mag, m_sign); end
    checks++; if (m_primed !== 3'b000 || m_ov !== 1'b1) begin errors++; $display("[TB] FAIL clear next primed/valid: got %b/%b expected 000/1", m_primed, m_ov); end
  endtask

  task automatic test_async_reset();
    do_clear();
    send(16'd10, 1'b1);
    send(16'd20, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_mag !== 48'd0 || m_sign !== 3'b111) begin errors++; $display("[TB] FAIL async dd: got %h/%b expected 0/111", m_mag, m_sign); end
    checks++; if (m_primed !== 3'b000 || m_ov !== 1'b0) begin errors++; $display("[TB] FAIL async primed/valid: got %b/%b expected 000/0", m_primed, m_ov); end
    checks++; if (o8_mag !== 128'd0 || o8_sign !== 8'hFF) begin errors++; $display("[TB] FAIL async o8: got %h/%h expected 0/ff", o8_mag, o8_sign); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_ramp("rst_ramp");
  endtask

  initial begin
    test_reset();
    test_ramp("ramp");
    test_quadratic();
    test_overflow();
    test_signed_zero();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
